// File: rtl/pll_reset_sequencer.sv
// Turns PLL lock into a staged reset tree: core release after a stable lock, then peripheral release.
// Outputs are registered; lock loss is seen SYNC_STAGES+1 clocks after pll_lock falls. No backpressure.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGE_GAP     = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pll_lock,
    output logic             reset_core,
    output logic             reset_periph,
    output logic             ready,
    output logic [CNT_W-1:0] lock_lost_cnt
);

    localparam int MAXC = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]    GAP_LAST    = CW'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] LOSS_MAX    = '1;

    typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, STAGE, RUN} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CNT_W-1:0]       loss_q, loss_d;
    logic                   core_q, core_d;
    logic                   periph_q, periph_d;
    logic                   ready_q, ready_d;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            loss_q   <= '0;
            core_q   <= 1'b1;
            periph_q <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pll_lock};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            loss_q   <= loss_d;
            core_q   <= core_d;
            periph_q <= periph_d;
            ready_q  <= ready_d;
        end
    end

    // Lock loss in STAGE wins over the STAGE->RUN step in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        unique case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = STAGE;
                    end else begin
                        state_d = STABILIZE;
                        cnt_d   = CW'(1);
                    end
                end
            end
            STABILIZE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = STAGE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STAGE, RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    if (loss_q != LOSS_MAX) loss_d = loss_q + CNT_W'(1);
                end else if (state_q == STAGE) begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        core_d   = (state_d == WAIT_LOCK) || (state_d == STABILIZE);
        periph_d = (state_d != RUN);
        ready_d  = (state_d == RUN);
    end

    assign reset_core    = core_q;
    assign reset_periph  = periph_q;
    assign ready         = ready_q;
    assign lock_lost_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed vectors for pll_reset_sequencer; a second instance with a 2-bit loss counter covers saturation.
module tb_pll_reset_sequencer;

    logic       clock    = 1'b0;
    logic       reset_n  = 1'b0;
    logic       pll_lock = 1'b1;
    logic       reset_core, reset_periph, ready;
    logic [7:0] lock_lost_cnt;
    logic       core2, periph2, ready2;
    logic [1:0] cnt2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    pll_reset_sequencer dut (
        .clock(clock), .reset_n(reset_n), .pll_lock(pll_lock),
        .reset_core(reset_core), .reset_periph(reset_periph),
        .ready(ready), .lock_lost_cnt(lock_lost_cnt)
    );

    pll_reset_sequencer #(.CNT_W(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .pll_lock(pll_lock),
        .reset_core(core2), .reset_periph(periph2),
        .ready(ready2), .lock_lost_cnt(cnt2)
    );

    typedef struct packed {
        logic        rst_n;
        logic        lock;
        logic [11:0] cyc;
        logic        core;
        logic        periph;
        logic        rdy;
        logic [7:0]  cnt;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic l, input int c,
                                input logic co, input logic pe, input logic rd, input int n);
        vec_t v;
        v.rst_n = r; v.lock = l; v.cyc = 12'(c);
        v.core = co; v.periph = pe; v.rdy = rd; v.cnt = 8'(n);
        return v;
    endfunction

    function automatic logic [1:0] sat2(input logic [7:0] n);
        return (n > 8'd3) ? 2'd3 : n[1:0];
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, got, exp);
        end
    endtask

    task automatic chk_both(input string nm, input int idx, input logic co, input logic pe,
                            input logic rd, input logic [7:0] n);
        chk(nm, idx, {5'd0, reset_core, reset_periph, ready, lock_lost_cnt}, {5'd0, co, pe, rd, n});
        chk({nm, "_w2"}, idx, {11'd0, core2, periph2, ready2, cnt2}, {11'd0, co, pe, rd, sat2(n)});
    endtask

    // Peripheral must never be out of reset while core is still held.
    always @(negedge clock) begin
        if (!reset_periph && reset_core) begin
            n_bad++;
            $display("FAIL invariant periph released while core in reset");
        end
    end

    logic [1:0] sat_exp [5];

    initial begin
        // power-up, loss in RUN, loss in STAGE, chatter, loss on the last STAGE cycle
        vecs[0]  = mk(0, 1,    5, 1, 1, 0, 0);
        vecs[1]  = mk(1, 1, 1025, 1, 1, 0, 0);
        vecs[2]  = mk(1, 1,    1, 0, 1, 0, 0);
        vecs[3]  = mk(1, 1,   15, 0, 1, 0, 0);
        vecs[4]  = mk(1, 1,    1, 0, 0, 1, 0);
        vecs[5]  = mk(1, 1,   20, 0, 0, 1, 0);
        vecs[6]  = mk(1, 0,    2, 0, 0, 1, 0);
        vecs[7]  = mk(1, 0,    1, 1, 1, 0, 1);
        vecs[8]  = mk(1, 0,    7, 1, 1, 0, 1);
        vecs[9]  = mk(1, 1, 1025, 1, 1, 0, 1);
        vecs[10] = mk(1, 1,    1, 0, 1, 0, 1);
        vecs[11] = mk(1, 1,   16, 0, 0, 1, 1);
        vecs[12] = mk(1, 0,    3, 1, 1, 0, 2);
        vecs[13] = mk(1, 1, 1026, 0, 1, 0, 2);
        vecs[14] = mk(1, 1,    5, 0, 1, 0, 2);
        vecs[15] = mk(1, 0,    2, 0, 1, 0, 2);
        vecs[16] = mk(1, 0,    1, 1, 1, 0, 3);
        vecs[17] = mk(1, 0,   20, 1, 1, 0, 3);
        vecs[18] = mk(1, 1,  500, 1, 1, 0, 3);
        vecs[19] = mk(1, 0,    3, 1, 1, 0, 3);
        vecs[20] = mk(1, 1, 1025, 1, 1, 0, 3);
        vecs[21] = mk(1, 1,    1, 0, 1, 0, 3);
        vecs[22] = mk(1, 1,   16, 0, 0, 1, 3);
        vecs[23] = mk(1, 0,    3, 1, 1, 0, 4);
        vecs[24] = mk(1, 1, 1026, 0, 1, 0, 4);
        vecs[25] = mk(1, 1,   13, 0, 1, 0, 4);
        vecs[26] = mk(1, 0,    2, 0, 1, 0, 4);
        vecs[27] = mk(1, 0,    1, 1, 1, 0, 5);

        for (int i = 0; i < NV; i++) begin
            reset_n  = vecs[i].rst_n;
            pll_lock = vecs[i].lock;
            repeat (int'(vecs[i].cyc)) @(negedge clock);
            chk_both("vec", i, vecs[i].core, vecs[i].periph, vecs[i].rdy, vecs[i].cnt);
        end

        // Saturation: five losses from RUN
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk_both("sat_reset", 0, 1, 1, 0, 0);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pll_lock = 1'b1;
            repeat (1042) @(negedge clock);
            chk("sat_run", k, {15'd0, ready2}, 16'd1);
            pll_lock = 1'b0;
            repeat (3) @(negedge clock);
            chk("sat_cnt2", k, {14'd0, cnt2}, {14'd0, sat_exp[k]});
            chk("sat_cnt8", k, {8'd0, lock_lost_cnt}, 16'(k + 1));
        end

        // Async reset mid-STABILIZE, then fresh full-length sequence
        pll_lock = 1'b1;
        repeat (500) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 chk_both("async_stab", 0, 1, 1, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (1025) @(negedge clock);
        chk_both("restart_hold", 0, 1, 1, 0, 0);
        @(negedge clock);
        chk_both("restart_fall", 0, 0, 1, 0, 0);

        // One loss, relock to RUN, then async reset mid-RUN
        repeat (16) @(negedge clock);
        pll_lock = 1'b0;
        repeat (3) @(negedge clock);
        pll_lock = 1'b1;
        repeat (1042) @(negedge clock);
        chk_both("run_again", 0, 0, 0, 1, 1);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 chk_both("async_run", 0, 1, 1, 0, 0);
        @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
